ahb_host_cmd_queue: RTL

Host-side command queue that sits directly upstream of the AHB bus master and drives its host_read/host_write/host_cont/host_size/host_addr/host_wdata request interface. It buffers host read/write commands in a command FIFO and presents them to the master one at a time. It computes host_cont for sequential back-to-back accesses and collects read data into a response FIFO drained by the host. The host thereby decouples from AHB arbitration and wait-state latency.

---
 rtl/ahb_host_cmd_queue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ahb_host_cmd_queue.sv
// Host-side command queue in front of the AHB master: buffers read/write commands,
// presents them one at a time, flags sequential continuation and buffers read data.
module ahb_host_cmd_queue #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_err,
  output logic              host_read,
  output logic              host_write,
  output logic              host_cont,
  output logic [2:0]        host_size,
  output logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_wdata,
  input  logic              bus_wready,
  input  logic              bus_rdone,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned RAW = $clog2(RSP_DEPTH);
  localparam int unsigned RPW = RAW + 1;

  typedef struct packed {
    logic              write;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  cmd_t              cmd_mem [CMD_DEPTH];
  logic [CAW:0]      cmd_wptr_q, cmd_rptr_q;
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RAW:0]      rsp_wptr_q, rsp_rptr_q, rsp_cnt;

  state_e            state_q;
  logic              init_q, cmd_err_q;
  logic              host_read_q, host_write_q, host_cont_q;
  logic [2:0]        host_size_q;
  logic [ADDR_W-1:0] host_addr_q, seq_addr;
  logic [DATA_W-1:0] host_wdata_q;

  cmd_t head;
  logic cmd_empty, cmd_full, cmd_legal, cmd_accept, cmd_push;
  logic done, rsp_push, rsp_pop, rsp_room, head_ok, load, cont_d;

  // Command FIFO flags and admission of new commands.
  always_comb begin
    cmd_empty  = (cmd_wptr_q == cmd_rptr_q);
    cmd_full   = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                 (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);
    cmd_ready  = init_q & ~cmd_full;
    cmd_legal  = 1'b0;
    case (cmd_size)
      3'd0:    cmd_legal = 1'b1;
      3'd1:    cmd_legal = ~cmd_addr[0];
      3'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
    cmd_accept = cmd_valid & cmd_ready;
    cmd_push   = cmd_accept & cmd_legal;
  end

  // Completion, response room and the decision to load the next head.
  always_comb begin
    head     = cmd_mem[cmd_rptr_q[CAW-1:0]];
    done     = ((state_q == StWr) && bus_wready) || ((state_q == StRd) && bus_rdone);
    rsp_push = (state_q == StRd) && bus_rdone;
    rsp_cnt  = rsp_wptr_q - rsp_rptr_q;
    rsp_pop  = rsp_valid & rsp_ready;
    // A read may only issue if its eventual data has a slot, counting the push happening now.
    rsp_room = rsp_push ? (rsp_cnt < RPW'(RSP_DEPTH - 1)) : (rsp_cnt < RPW'(RSP_DEPTH));
    head_ok  = ~cmd_empty & (head.write | rsp_room);
    load     = head_ok && ((state_q == StIdle) || done);
    seq_addr = host_addr_q + (ADDR_W'(1) << host_size_q);
    cont_d   = (state_q != StIdle) && (head.write == host_write_q) &&
               (head.size == host_size_q) && (head.addr == seq_addr) &&
               (head.addr[9:0] != 10'd0);
  end

  // Command FIFO pointers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
    end else begin
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
      if (load)     cmd_rptr_q <= cmd_rptr_q + 1'b1;
    end
  end

  // Command FIFO storage.
  always_ff @(posedge hclk) begin
    if (cmd_push) cmd_mem[cmd_wptr_q[CAW-1:0]] <= {cmd_write, cmd_size, cmd_addr, cmd_wdata};
  end

  // Response FIFO pointers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
    end else begin
      if (rsp_push) rsp_wptr_q <= rsp_wptr_q + 1'b1;
      if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + 1'b1;
    end
  end

  // Response FIFO storage.
  always_ff @(posedge hclk) begin
    if (rsp_push) rsp_mem[rsp_wptr_q[RAW-1:0]] <= bus_rdata;
  end

  // Ready-after-reset flag and rejected-command pulse.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      init_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      init_q    <= 1'b1;
      cmd_err_q <= cmd_accept & ~cmd_legal;
    end
  end

  // Request FSM with registered request outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q      <= StIdle;
      host_read_q  <= 1'b0;
      host_write_q <= 1'b0;
      host_cont_q  <= 1'b0;
      host_size_q  <= '0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
    end else if (load) begin
      state_q      <= head.write ? StWr : StRd;
      host_write_q <= head.write;
      host_read_q  <= ~head.write;
      host_cont_q  <= cont_d;
      host_size_q  <= head.size;
      host_addr_q  <= head.addr;
      host_wdata_q <= head.wdata;
    end else if (done) begin
      state_q      <= StIdle;
      host_write_q <= 1'b0;
      host_read_q  <= 1'b0;
      host_cont_q  <= 1'b0;
    end
  end

  // Output drive; response data is forced to zero while the FIFO is empty.
  always_comb begin
    cmd_err    = cmd_err_q;
    host_read  = host_read_q;
    host_write = host_write_q;
    host_cont  = host_cont_q;
    host_size  = host_size_q;
    host_addr  = host_addr_q;
    host_wdata = host_wdata_q;
    rsp_valid  = (rsp_wptr_q != rsp_rptr_q);
    rsp_data   = rsp_valid ? rsp_mem[rsp_rptr_q[RAW-1:0]] : '0;
    busy       = (state_q != StIdle) | ~cmd_empty;
  end

endmodule
